// File: rtl/round_robin_arbiter_with_2_requests_pkg.sv
// Shared types for the two-requester round-robin arbiter.
package round_robin_arbiter_with_2_requests_pkg;

  localparam int unsigned N_REQ = 2;

  typedef logic [N_REQ-1:0] req_vec_t;

  // Index of the most recently granted requester.
  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_e;

endpackage

// File: rtl/round_robin_arbiter_with_2_requests_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface round_robin_arbiter_with_2_requests_if;
  import round_robin_arbiter_with_2_requests_pkg::*;

  req_vec_t requests;
  req_vec_t grants;

  modport master (output requests, input grants);
  modport slave  (input requests, output grants);

endinterface

// File: rtl/round_robin_arbiter_with_2_requests.sv
// Two-requester round-robin arbiter: combinational grant, one-bit priority register.
module round_robin_arbiter_with_2_requests
  import round_robin_arbiter_with_2_requests_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst,
  round_robin_arbiter_with_2_requests_if.slave     bus
);

  req_idx_e last_grant_q;
  req_idx_e last_grant_d;
  req_vec_t grants;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= REQ1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    grants = '0;
    if (rst) begin
      unique case (bus.requests)
        2'b01:   grants = 2'b01;
        2'b10:   grants = 2'b10;
        2'b11:   grants = (last_grant_q == REQ1) ? 2'b01 : 2'b10;
        default: grants = '0;
      endcase
    end
  end

  // Idle cycles leave priority untouched so fairness survives gaps.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grants[0]) begin
      last_grant_d = REQ0;
    end else if (grants[1]) begin
      last_grant_d = REQ1;
    end
  end

  assign bus.grants = grants;

`ifndef SYNTHESIS
  a_onehot0: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(bus.grants));

  a_no_spurious: assert property (@(posedge clk) disable iff (!rst)
    (bus.grants & ~bus.requests) == '0);

  a_work_conserving: assert property (@(posedge clk) disable iff (!rst)
    (bus.requests != '0) |-> (bus.grants != '0));

  a_alternate: assert property (@(posedge clk) disable iff (!rst)
    (bus.requests == 2'b11) |=>
      ((bus.requests != 2'b11) || (bus.grants != $past(bus.grants))));
`endif

endmodule

// File: tb/tb_round_robin_arbiter_with_2_requests.sv
// Directed and model-checked random stimulus for the two-requester arbiter.
module tb_round_robin_arbiter_with_2_requests;
  import round_robin_arbiter_with_2_requests_pkg::*;

  logic clk;
  logic rst;
  int unsigned n_tests;
  int unsigned n_fail;

  round_robin_arbiter_with_2_requests_if bus ();

  round_robin_arbiter_with_2_requests u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input req_vec_t got, input req_vec_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, check grants mid-cycle, then clock.
  task automatic step(input req_vec_t req, input req_vec_t exp, input string tag);
    bus.requests = req;
    @(negedge clk);
    check(tag, bus.grants, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.requests = 2'b11;
    @(negedge clk);
    check("reset_grants", bus.grants, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  req_vec_t seq_req [32];
  req_vec_t seq_exp [32];
  req_vec_t exp_g;
  req_vec_t r;
  logic     lg_m;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.requests = '0;
    @(posedge clk);
    #1;

    do_reset();
    step(2'b11, 2'b01, "cont4_0");
    step(2'b11, 2'b10, "cont4_1");
    step(2'b11, 2'b01, "cont4_2");
    step(2'b11, 2'b10, "cont4_3");

    do_reset();
    step(2'b01, 2'b01, "lone0_a");
    step(2'b01, 2'b01, "lone0_b");
    step(2'b11, 2'b10, "lone0_cont");

    do_reset();
    step(2'b10, 2'b10, "lone1");
    step(2'b11, 2'b01, "lone1_cont");

    do_reset();
    step(2'b11, 2'b01, "idle_c0");
    step(2'b00, 2'b00, "idle_0");
    step(2'b00, 2'b00, "idle_1");
    step(2'b11, 2'b10, "idle_c1");
    step(2'b01, 2'b01, "force01");
    step(2'b10, 2'b10, "force10");
    step(2'b01, 2'b01, "force01_b");

    // Mid-stream reset while contending.
    bus.requests = 2'b11;
    @(negedge clk);
    check("pre_mid_rst", bus.grants, 2'b10);
    rst = 1'b0;
    #1;
    check("mid_rst_now", bus.grants, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(2'b11, 2'b01, "after_rst");

    seq_req = '{2'b00,2'b01,2'b01,2'b11,2'b01,2'b01,2'b01,2'b10,2'b01,2'b01,2'b10,2'b01,2'b01,2'b00,2'b01,2'b10,
                2'b01,2'b10,2'b01,2'b11,2'b10,2'b11,2'b10,2'b10,2'b00,2'b01,2'b00,2'b01,2'b01,2'b01,2'b11,2'b10};
    seq_exp = '{2'b00,2'b01,2'b01,2'b10,2'b01,2'b01,2'b01,2'b10,2'b01,2'b01,2'b10,2'b01,2'b01,2'b00,2'b01,2'b10,
                2'b01,2'b10,2'b01,2'b10,2'b10,2'b01,2'b10,2'b10,2'b00,2'b01,2'b00,2'b01,2'b01,2'b01,2'b10,2'b10};
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(seq_req[i], seq_exp[i], $sformatf("seq32_%0d", i));
    end

    do_reset();
    lg_m = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r = req_vec_t'($urandom_range(0, 3));
      case (r)
        2'b00:   exp_g = 2'b00;
        2'b01:   exp_g = 2'b01;
        2'b10:   exp_g = 2'b10;
        default: exp_g = lg_m ? 2'b01 : 2'b10;
      endcase
      step(r, exp_g, "random");
      if (exp_g != 2'b00) lg_m = exp_g[1];
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
